// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
// Covers opcodes, state encoding, ALU/mux select codes and the control vector.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Encodings 12..15 are unused and fall back to FETCH with all outputs low.
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   typedef struct packed {
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       branch_ne;
      logic       iord;
      logic       memwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       zext;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_is_known(input logic [5:0] opcode);
      case (opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface multicycle_main_fsm_if #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 2
);
   logic [OP_W-1:0]    op;
   logic               zero;
   logic               mem_ready;
   logic               irwrite;
   logic               pcwrite;
   logic               pcen;
   logic               branch;
   logic               branch_ne;
   logic               iord;
   logic               memwrite;
   logic               memtoreg;
   logic               regdst;
   logic               regwrite;
   logic               alusrca;
   logic [1:0]         alusrcb;
   logic               zext;
   logic [1:0]         pcsrc;
   logic [ALUOP_W-1:0] aluop;
   logic               illegal_op;

   modport master (
      input  op, zero, mem_ready,
      output irwrite, pcwrite, pcen, branch, branch_ne, iord, memwrite, memtoreg,
             regdst, regwrite, alusrca, alusrcb, zext, pcsrc, aluop, illegal_op
   );

   modport slave (
      output op, zero, mem_ready,
      input  irwrite, pcwrite, pcen, branch, branch_ne, iord, memwrite, memtoreg,
             regdst, regwrite, alusrca, alusrcb, zext, pcsrc, aluop, illegal_op
   );
endinterface

// File: rtl/main_fsm_outdec.sv
// Moore output decode: current state (plus op / mem_ready where needed) to control vector.
module main_fsm_outdec
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  state_t          state,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.pcsrc   = PCSRC_ALU;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         S_DECODE: begin
            ctrl.alusrcb    = SRCB_IMM_SH2;
            ctrl.aluop      = ALUOP_ADD;
            ctrl.illegal_op = ~op_is_known(op);
         end
         S_MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         S_EXEC: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_REG;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alusrca   = 1'b1;
            ctrl.alusrcb   = SRCB_REG;
            ctrl.aluop     = ALUOP_SUB;
            ctrl.pcsrc     = PCSRC_ALUOUT;
            ctrl.branch    = (op == OP_BEQ);
            ctrl.branch_ne = (op == OP_BNE);
         end
         S_IMMEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            // ORI needs a zero-extended immediate; ADDI keeps sign extension.
            if (op == OP_ORI) begin
               ctrl.aluop = ALUOP_OR;
               ctrl.zext  = 1'b1;
            end else begin
               ctrl.aluop = ALUOP_ADD;
            end
         end
         S_IMMWB: ctrl.regwrite = 1'b1;
         S_JUMP: begin
            ctrl.pcsrc   = PCSRC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic, pcen and optional
// retired-instruction counter (enabled by defining MAIN_FSM_PERF_CNT_EN).
module multicycle_main_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 2,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_main_fsm_if.master bus
`ifdef MAIN_FSM_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     instr_retired
`endif
);

   state_t state_q, state_d;
   ctrl_t  ctrl;

   main_fsm_outdec #(.OP_W(OP_W)) u_outdec (
      .state     (state_q),
      .op        (bus.op),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               OP_RTYPE:        state_d = S_EXEC;
               OP_LW, OP_SW:    state_d = S_MEMADR;
               OP_BEQ, OP_BNE:  state_d = S_BRANCH;
               OP_ADDI, OP_ORI: state_d = S_IMMEX;
               OP_J:            state_d = S_JUMP;
               default:         state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_IMMEX:  state_d = S_IMMWB;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign bus.irwrite    = ctrl.irwrite;
   assign bus.pcwrite    = ctrl.pcwrite;
   assign bus.pcen       = ctrl.pcwrite | (ctrl.branch & bus.zero) | (ctrl.branch_ne & ~bus.zero);
   assign bus.branch     = ctrl.branch;
   assign bus.branch_ne  = ctrl.branch_ne;
   assign bus.iord       = ctrl.iord;
   assign bus.memwrite   = ctrl.memwrite;
   assign bus.memtoreg   = ctrl.memtoreg;
   assign bus.regdst     = ctrl.regdst;
   assign bus.regwrite   = ctrl.regwrite;
   assign bus.alusrca    = ctrl.alusrca;
   assign bus.alusrcb    = ctrl.alusrcb;
   assign bus.zext       = ctrl.zext;
   assign bus.pcsrc      = ctrl.pcsrc;
   assign bus.aluop      = ALUOP_W'(ctrl.aluop);
   assign bus.illegal_op = ctrl.illegal_op;

`ifdef MAIN_FSM_PERF_CNT_EN
   logic             retire;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // An illegal-opcode return leaves DECODE, so it never counts as a retirement.
   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: retire = 1'b1;
         S_MEMWR: retire = bus.mem_ready;
         default: ;
      endcase
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign instr_retired = cnt_q;
`else
   logic cnt_w_unused;
   assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed self-checking bench for multicycle_main_fsm; counter checks need MAIN_FSM_PERF_CNT_EN.
module tb_multicycle_main_fsm;

   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   multicycle_main_fsm_if #(.OP_W(6), .ALUOP_W(2)) bus ();

`ifdef MAIN_FSM_PERF_CNT_EN
   logic [CNT_W-1:0] instr_retired;
`endif

   multicycle_main_fsm #(.OP_W(6), .ALUOP_W(2), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MAIN_FSM_PERF_CNT_EN
      ,
      .instr_retired (instr_retired)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] op_v, input logic zero_v, input logic ready_v);
      bus.op        = op_v;
      bus.zero      = zero_v;
      bus.mem_ready = ready_v;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state, with and without mem_ready
      reset = 1'b1;
      applyStimulus(6'b000000, 1'b0, 1'b0);
      checkOutput("rst_irwrite", bus.irwrite, 0);
      checkOutput("rst_alusrcb", bus.alusrcb, 1);
      checkOutput("rst_aluop", bus.aluop, 0);
      checkOutput("rst_pcen", bus.pcen, 0);
      checkOutput("rst_memwrite", bus.memwrite, 0);
      checkOutput("rst_regwrite", bus.regwrite, 0);
      applyStimulus(6'b000000, 1'b0, 1'b1);
      checkOutput("rst_irwrite_rdy", bus.irwrite, 1);
      checkOutput("rst_pcwrite_rdy", bus.pcwrite, 1);
      checkOutput("rst_pcen_rdy", bus.pcen, 1);
`ifdef MAIN_FSM_PERF_CNT_EN
      checkOutput("rst_cnt", instr_retired, 0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // ADDI with mem_ready tied high
      applyStimulus(6'b001000, 1'b0, 1'b1);
      checkOutput("addi_f_irwrite", bus.irwrite, 1);
      tick();
      checkOutput("addi_d_alusrcb", bus.alusrcb, 3);
      checkOutput("addi_d_irwrite", bus.irwrite, 0);
      checkOutput("addi_d_illegal", bus.illegal_op, 0);
      tick();
      checkOutput("addi_x_aluop", bus.aluop, 0);
      checkOutput("addi_x_zext", bus.zext, 0);
      checkOutput("addi_x_alusrca", bus.alusrca, 1);
      checkOutput("addi_x_alusrcb", bus.alusrcb, 2);
      tick();
      checkOutput("addi_w_regwrite", bus.regwrite, 1);
      checkOutput("addi_w_regdst", bus.regdst, 0);
      checkOutput("addi_w_memtoreg", bus.memtoreg, 0);
      tick();
      checkOutput("addi_f5_irwrite", bus.irwrite, 1);
`ifdef MAIN_FSM_PERF_CNT_EN
      checkOutput("addi_cnt", instr_retired, 1);
`endif

      // SW stalled in MEMWR, then reset asserted mid-write
      applyStimulus(6'b101011, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("sw_a_alusrcb", bus.alusrcb, 2);
      checkOutput("sw_a_alusrca", bus.alusrca, 1);
      checkOutput("sw_a_memwrite", bus.memwrite, 0);
      applyStimulus(6'b101011, 1'b0, 1'b0);
      tick();
      checkOutput("sw_w_memwrite", bus.memwrite, 1);
      checkOutput("sw_w_iord", bus.iord, 1);
      tick();
      checkOutput("sw_w2_memwrite", bus.memwrite, 1);
      reset = 1'b1;
      #1;
      checkOutput("sw_rst_memwrite", bus.memwrite, 0);
      checkOutput("sw_rst_iord", bus.iord, 0);
      checkOutput("sw_rst_alusrcb", bus.alusrcb, 1);
`ifdef MAIN_FSM_PERF_CNT_EN
      checkOutput("sw_rst_cnt", instr_retired, 0);
`endif
      applyStimulus(6'b100011, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("sw_rel_irwrite", bus.irwrite, 1);
      checkOutput("sw_rel_memwrite", bus.memwrite, 0);

      // LW: FETCH waits 3 cycles, MEMRD waits 2 cycles
      applyStimulus(6'b100011, 1'b0, 1'b0);
      checkOutput("lw_f1_irwrite", bus.irwrite, 0);
      tick();
      checkOutput("lw_f2_irwrite", bus.irwrite, 0);
      checkOutput("lw_f2_alusrcb", bus.alusrcb, 1);
      tick();
      checkOutput("lw_f3_irwrite", bus.irwrite, 0);
      tick();
      applyStimulus(6'b100011, 1'b0, 1'b1);
      checkOutput("lw_f4_irwrite", bus.irwrite, 1);
      tick();
      checkOutput("lw_d_alusrcb", bus.alusrcb, 3);
      tick();
      checkOutput("lw_a_alusrcb", bus.alusrcb, 2);
      applyStimulus(6'b100011, 1'b0, 1'b0);
      tick();
      checkOutput("lw_r1_iord", bus.iord, 1);
      checkOutput("lw_r1_memwrite", bus.memwrite, 0);
      tick();
      checkOutput("lw_r2_iord", bus.iord, 1);
      applyStimulus(6'b100011, 1'b0, 1'b1);
      checkOutput("lw_r3_iord", bus.iord, 1);
      tick();
      checkOutput("lw_wb_memtoreg", bus.memtoreg, 1);
      checkOutput("lw_wb_regwrite", bus.regwrite, 1);
      checkOutput("lw_wb_regdst", bus.regdst, 0);
      checkOutput("lw_wb_iord", bus.iord, 0);
      tick();
      checkOutput("lw_f_irwrite", bus.irwrite, 1);
`ifdef MAIN_FSM_PERF_CNT_EN
      checkOutput("lw_cnt", instr_retired, 1);
`endif

      // BNE taken (zero=0) then not taken (zero=1)
      applyStimulus(6'b000101, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("bne_pcen", bus.pcen, 1);
      checkOutput("bne_branch_ne", bus.branch_ne, 1);
      checkOutput("bne_branch", bus.branch, 0);
      checkOutput("bne_pcsrc", bus.pcsrc, 1);
      checkOutput("bne_aluop", bus.aluop, 1);
      applyStimulus(6'b000101, 1'b1, 1'b1);
      checkOutput("bne_z_pcen", bus.pcen, 0);
      tick();
      checkOutput("bne_f_irwrite", bus.irwrite, 1);

      // BEQ taken (zero=1) then not taken (zero=0)
      applyStimulus(6'b000100, 1'b1, 1'b1);
      tick();
      tick();
      checkOutput("beq_pcen", bus.pcen, 1);
      checkOutput("beq_branch", bus.branch, 1);
      checkOutput("beq_branch_ne", bus.branch_ne, 0);
      applyStimulus(6'b000100, 1'b0, 1'b1);
      checkOutput("beq_nz_pcen", bus.pcen, 0);
      tick();
`ifdef MAIN_FSM_PERF_CNT_EN
      checkOutput("beq_cnt", instr_retired, 3);
`endif

      // Illegal opcode
      applyStimulus(6'b111111, 1'b0, 1'b1);
      checkOutput("ill_f_illegal", bus.illegal_op, 0);
      tick();
      checkOutput("ill_d_illegal", bus.illegal_op, 1);
      checkOutput("ill_d_regwrite", bus.regwrite, 0);
      checkOutput("ill_d_memwrite", bus.memwrite, 0);
      tick();
      checkOutput("ill_f2_illegal", bus.illegal_op, 0);
      checkOutput("ill_f2_irwrite", bus.irwrite, 1);
      checkOutput("ill_f2_regwrite", bus.regwrite, 0);
`ifdef MAIN_FSM_PERF_CNT_EN
      checkOutput("ill_cnt", instr_retired, 3);
`endif

      // R-type
      applyStimulus(6'b000000, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("rt_x_aluop", bus.aluop, 2);
      checkOutput("rt_x_alusrcb", bus.alusrcb, 0);
      checkOutput("rt_x_alusrca", bus.alusrca, 1);
      tick();
      checkOutput("rt_w_regdst", bus.regdst, 1);
      checkOutput("rt_w_regwrite", bus.regwrite, 1);
      tick();

      // ORI
      applyStimulus(6'b001101, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("ori_x_aluop", bus.aluop, 3);
      checkOutput("ori_x_zext", bus.zext, 1);
      tick();
      checkOutput("ori_w_regwrite", bus.regwrite, 1);
      tick();

      // J
      applyStimulus(6'b000010, 1'b0, 1'b1);
      tick();
      tick();
      checkOutput("j_pcsrc", bus.pcsrc, 2);
      checkOutput("j_pcwrite", bus.pcwrite, 1);
      checkOutput("j_pcen", bus.pcen, 1);
      checkOutput("j_irwrite", bus.irwrite, 0);
      tick();
      checkOutput("j_f_irwrite", bus.irwrite, 1);
`ifdef MAIN_FSM_PERF_CNT_EN
      checkOutput("j_cnt", instr_retired, 6);

      // 17 back-to-back jumps from a cleared counter wrap a 4-bit count to 1
      reset = 1'b1;
      #1;
      checkOutput("wrap_rst_cnt", instr_retired, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         tick();
         tick();
         tick();
         if (n == 16) checkOutput("wrap16_cnt", instr_retired, 0);
      end
      checkOutput("wrap17_cnt", instr_retired, 1);
      checkOutput("wrap17_irwrite", bus.irwrite, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Multicycle MIPS control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/execute/writeback states. Drives datapath enables from the current state (Moore).
- Stalls on a memory-ready handshake.
- Adds BNE and ORI and flags illegal opcodes. Sits between the instruction register opcode field and the shared-memory multicycle datapath.

Parameters:
- OP_W, 6, opcode field width.
- ALUOP_W, 2, aluop output width. Must be >=2; codes occupy the low 2 bits and upper bits are 0.
- CNT_W, 32, retired-instruction counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- op  in  OP_W  opcode from the instruction register (stable after FETCH).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  unconditional PC write.
- pcen  out  1  pcwrite | (branch & zero) | (branch_ne & ~zero).
- branch  out  1  BEQ compare cycle.
- branch_ne  out  1  BNE compare cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- memtoreg  out  1  writeback select: 1 = memory data.
- regdst  out  1  destination register select: 1 = rd, 0 = rt.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- zext  out  1  immediate extension: zero-extend when 1, sign-extend when 0.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- aluop  out  ALUOP_W  ALU operation: 00 = add, 01 = sub, 10 = funct, 11 = or.
- illegal_op  out  1  unrecognised opcode, pulsed in DECODE.

Behaviour:
- State register is 4 bits. Async reset sets state to FETCH. All outputs are combinational from state (plus op, zero, mem_ready where stated).
- Every output not listed for a state is 0.
- Reset values (state FETCH): iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=pcen=mem_ready, all other outputs 0.
- FETCH:
  - Drives alusrcb=01, aluop=add, irwrite=pcwrite=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrcb=11, aluop=add. Next state by op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 or 000101 -> BRANCH
  - 001000 or 001101 -> IMMEX
  - 000010 -> JUMP
  - any other op -> FETCH, with illegal_op=1 for this single cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=add. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1, regdst=0. Next state FETCH.
- MEMWR: iord=1, memwrite=1. memwrite stays high every cycle until mem_ready=1, then FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=funct. Next state ALUWB.
- ALUWB: regdst=1, regwrite=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=(op==000100), branch_ne=(op==000101). Next state FETCH.
- IMMEX: alusrca=1, alusrcb=10. For ADDI: aluop=add, zext=0. For ORI: aluop=or, zext=1. Next state IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- Latency in cycles, excluding memory wait cycles:
  - R-type, ADDI, ORI: 4
  - LW: 5
  - SW: 4
  - BEQ, BNE, J: 3
- Unused state encodings: return to FETCH on the next clock, all outputs 0.
- Reset asserted mid-instruction: immediate return to FETCH. No partial writes occur after reset assertion.

Optional Feature:
- Macro MAIN_FSM_PERF_CNT_EN.
- Defined:
  - Adds output instr_retired [CNT_W-1:0], reset to 0.
  - Increments by 1 on each transition to FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, IMMWB or JUMP.
  - Does not increment on an illegal-opcode return.
  - Wraps modulo 2^CNT_W.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J);
  - the state enum (4-bit);
  - ALUOP codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_OR);
  - alusrcb and pcsrc codes.
- One natural sub-module, main_fsm_outdec: pure combinational state/op -> control vector. The top holds the state register, next-state logic, pcen and the counter.

Test Plan:
- Reset asserted mid-MEMWR (memwrite=1): memwrite drops to 0 with no clock edge, state FETCH; after release with mem_ready=1, irwrite=1 on the first cycle.
- ADDI (op=001000) with mem_ready tied to 1: FETCH, DECODE, IMMEX (aluop=00, zext=0), IMMWB (regwrite=1, regdst=0); next FETCH on cycle 5.
- LW with mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEMRD: FETCH lasts 4 cycles with irwrite=0 until the last; MEMRD lasts 3 cycles; MEMWB has memtoreg=1, regwrite=1.
- BNE (op=000101): zero=0 in BRANCH gives pcen=1, branch_ne=1, pcsrc=01; repeat with zero=1 gives pcen=0; BEQ with zero=1 gives pcen=1.
- op=111111: illegal_op=1 for exactly the DECODE cycle, then FETCH; no regwrite or memwrite at any point; with MAIN_FSM_PERF_CNT_EN, instr_retired is unchanged.
- With MAIN_FSM_PERF_CNT_EN and CNT_W=4: 17 back-to-back J instructions leave instr_retired=1 (wrap); ORI gives aluop=11, zext=1 in IMMEX.
